// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the memory-access stage.
//   mem_size_e  : access size decoded from funct3[1:0]
//   mem_state_e : bus transaction FSM state
//   NumLanes    : byte lanes (and byte-enable width) of the 32-bit bus
package mem_pkg;

  localparam int unsigned LaneW    = 8;
  localparam int unsigned NumLanes = 4;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } mem_size_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_e;

  // funct3[1:0] == 2'b11 is not a legal size; it is treated as a word.
  function automatic mem_size_e decode_size(input logic [1:0] f);
    case (f)
      2'b00:   decode_size = BYTE;
      2'b01:   decode_size = HALF;
      default: decode_size = WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// load_align: combinational load-data lane select and extension.
// Ports:
//   rdata       in  32  raw read word from the bus
//   addr_lo     in  2   low address bits of the access
//   size        in      access size (BYTE/HALF/WORD)
//   is_unsigned in  1   1 = zero-extend, 0 = sign-extend
//   ext         out 32  aligned, extended load value
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  mem_size_e   size,
  input  logic        is_unsigned,
  output logic [31:0] ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (size)
      BYTE:    ext = {{24{byte_sel[7] & ~is_unsigned}}, byte_sel};
      HALF:    ext = {{16{half_sel[15] & ~is_unsigned}}, half_sel};
      default: ext = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage with MEM/WB register.
// Performs loads/stores over a single-outstanding req/ready bus, stalls
// upstream while a transaction is in flight, aligns/extends load data.
// Ports:
//   clk, rstn (async, active-low)
//   EX/MEM side : valid_in, mem_rd, mem_wr, funct3, rdn_in, alu_out, mem_data
//   stall       : upstream must hold EX/MEM
//   bus         : dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
//                 dmem_ready, dmem_rdata
//   MEM/WB      : wb_valid, wb_we, rdn, wb_data, misalign
// Build option: MEM_MISALIGN_TRAP_EN -- when defined, misaligned half/word
// accesses bypass the bus and retire with misalign=1 and the faulting
// address; otherwise the offending low address bits are cleared.
module mem_stage
  import mem_pkg::*;
#(
  parameter int unsigned WordSize = 32
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                valid_in,
  input  logic                mem_rd,
  input  logic                mem_wr,
  input  logic [2:0]          funct3,
  input  logic [4:0]          rdn_in,
  input  logic [WordSize-1:0] alu_out,
  input  logic [WordSize-1:0] mem_data,
  output logic                stall,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [WordSize-1:0] dmem_addr,
  output logic [NumLanes-1:0] dmem_be,
  output logic [WordSize-1:0] dmem_wdata,
  input  logic                dmem_ready,
  input  logic [WordSize-1:0] dmem_rdata,
  output logic                wb_valid,
  output logic                wb_we,
  output logic [4:0]          rdn,
  output logic [WordSize-1:0] wb_data,
  output logic                misalign
);

  mem_state_e state_q, state_d;

  // Captured transaction
  logic [WordSize-1:0] addr_q, addr_d;
  logic [NumLanes-1:0] be_q, be_d;
  logic [WordSize-1:0] wdata_q, wdata_d;
  logic                we_q, we_d;
  mem_size_e           size_q, size_d;
  logic                uns_q, uns_d;
  logic [4:0]          rdn_cap_q, rdn_cap_d;

  // MEM/WB register
  logic                wb_valid_q, wb_valid_d;
  logic                wb_we_q, wb_we_d;
  logic [4:0]          rdn_q, rdn_d;
  logic [WordSize-1:0] wb_data_q, wb_data_d;
  logic                misalign_q, misalign_d;

  mem_size_e           size_in;
  logic [WordSize-1:0] addr_fix;
  logic [NumLanes-1:0] be_in;
  logic [WordSize-1:0] wdata_in;
  logic [WordSize-1:0] load_word;
  logic                trap;

  load_align u_load_align (
    .rdata       (dmem_rdata),
    .addr_lo     (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .ext         (load_word)
  );

  // Lane preparation from the live EX/MEM inputs, evaluated at capture.
  always_comb begin
    size_in = decode_size(funct3[1:0]);
    case (size_in)
      BYTE: begin
        addr_fix = alu_out;
        be_in    = 4'b0001 << addr_fix[1:0];
        wdata_in = {4{mem_data[7:0]}};
      end
      HALF: begin
        addr_fix = {alu_out[WordSize-1:1], 1'b0};
        be_in    = 4'b0011 << {addr_fix[1], 1'b0};
        wdata_in = {2{mem_data[15:0]}};
      end
      default: begin
        addr_fix = {alu_out[WordSize-1:2], 2'b00};
        be_in    = 4'b1111;
        wdata_in = mem_data;
      end
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_comb begin
    trap = ((size_in == HALF) && alu_out[0]) ||
           ((size_in == WORD) && (alu_out[1:0] != 2'b00));
  end
`else
  assign trap = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    size_d     = size_q;
    uns_d      = uns_q;
    rdn_cap_d  = rdn_cap_q;
    // WB register defaults to a bubble; payload fields hold.
    wb_valid_d = 1'b0;
    wb_we_d    = 1'b0;
    misalign_d = 1'b0;
    rdn_d      = rdn_q;
    wb_data_d  = wb_data_q;

    case (state_q)
      IDLE: begin
        if (valid_in) begin
          if (mem_rd || mem_wr) begin
            if (trap) begin
              wb_valid_d = 1'b1;
              misalign_d = 1'b1;
              wb_data_d  = alu_out;
              rdn_d      = rdn_in;
            end else begin
              state_d   = BUSY;
              addr_d    = addr_fix;
              be_d      = be_in;
              wdata_d   = wdata_in;
              we_d      = mem_wr;
              size_d    = size_in;
              uns_d     = funct3[2];
              rdn_cap_d = rdn_in;
            end
          end else begin
            wb_valid_d = 1'b1;
            wb_we_d    = (rdn_in != 5'd0);
            wb_data_d  = alu_out;
            rdn_d      = rdn_in;
          end
        end
      end
      BUSY: begin
        if (dmem_ready) begin
          state_d    = IDLE;
          wb_valid_d = 1'b1;
          rdn_d      = rdn_cap_q;
          if (!we_q) begin
            wb_we_d   = (rdn_cap_q != 5'd0);
            wb_data_d = load_word;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      size_q     <= BYTE;
      uns_q      <= 1'b0;
      rdn_cap_q  <= '0;
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      rdn_q      <= '0;
      wb_data_q  <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      rdn_cap_q  <= rdn_cap_d;
      wb_valid_q <= wb_valid_d;
      wb_we_q    <= wb_we_d;
      rdn_q      <= rdn_d;
      wb_data_q  <= wb_data_d;
      misalign_q <= misalign_d;
    end
  end

  assign stall      = (state_q == BUSY);
  assign dmem_req   = (state_q == BUSY);
  assign dmem_we    = we_q;
  assign dmem_addr  = {addr_q[WordSize-1:2], 2'b00};
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;
  assign wb_valid   = wb_valid_q;
  assign wb_we      = wb_we_q;
  assign rdn        = rdn_q;
  assign wb_data    = wb_data_q;
  assign misalign   = misalign_q;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        valid_in = 1'b0, mem_rd = 1'b0, mem_wr = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [4:0]  rdn_in = '0;
  logic [31:0] alu_out = '0, mem_data = '0;
  logic        stall, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        wb_valid, wb_we, misalign;
  logic [4:0]  rdn;
  logic [31:0] wb_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_stage #(.WordSize(32)) dut (
    .clk(clk), .rstn(rstn), .valid_in(valid_in), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .funct3(funct3), .rdn_in(rdn_in), .alu_out(alu_out),
    .mem_data(mem_data), .stall(stall), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready),
    .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_we(wb_we),
    .rdn(rdn), .wb_data(wb_data), .misalign(misalign)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [4:0]  rdn_i;
    logic [31:0] alu;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          n_busy;    // BUSY cycles until ready (mem ops only)
    logic        is_mem;    // expect a bus transaction
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic        e_we;
    logic        e_wb_we;
    logic [31:0] e_data;
    logic        chk_data;
    logic        e_mis;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [31:0] addr_first;
    valid_in = 1'b1; mem_rd = v.rd; mem_wr = v.wr; funct3 = v.f3;
    rdn_in = v.rdn_i; alu_out = v.alu; mem_data = v.sdata;
    dmem_ready = 1'b0; dmem_rdata = '0;
    @(posedge clk); #1;
    valid_in = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
    if (!v.is_mem) begin
      check($sformatf("v%0d wb_valid", idx), {31'd0, wb_valid}, 32'd1);
      check($sformatf("v%0d wb_we", idx), {31'd0, wb_we}, {31'd0, v.e_wb_we});
      check($sformatf("v%0d rdn", idx), {27'd0, rdn}, {27'd0, v.rdn_i});
      check($sformatf("v%0d wb_data", idx), wb_data, v.e_data);
      check($sformatf("v%0d misalign", idx), {31'd0, misalign}, {31'd0, v.e_mis});
      check($sformatf("v%0d stall", idx), {31'd0, stall}, 32'd0);
      check($sformatf("v%0d no_req", idx), {31'd0, dmem_req}, 32'd0);
    end else begin
      check($sformatf("v%0d req", idx), {31'd0, dmem_req}, 32'd1);
      check($sformatf("v%0d addr", idx), dmem_addr, v.e_addr);
      check($sformatf("v%0d be", idx), {28'd0, dmem_be}, {28'd0, v.e_be});
      check($sformatf("v%0d we", idx), {31'd0, dmem_we}, {31'd0, v.e_we});
      if (v.e_we) check($sformatf("v%0d wdata", idx), dmem_wdata, v.e_wdata);
      check($sformatf("v%0d bubble", idx), {31'd0, wb_valid}, 32'd0);
      addr_first = dmem_addr;
      for (int k = 1; k <= v.n_busy; k++) begin
        check($sformatf("v%0d stall_c%0d", idx, k), {31'd0, stall}, 32'd1);
        check($sformatf("v%0d addr_hold_c%0d", idx, k), dmem_addr, addr_first);
        dmem_ready = (k == v.n_busy);
        dmem_rdata = (k == v.n_busy) ? v.rdata : 32'h0;
        @(posedge clk); #1;
      end
      dmem_ready = 1'b0;
      check($sformatf("v%0d done_valid", idx), {31'd0, wb_valid}, 32'd1);
      check($sformatf("v%0d done_we", idx), {31'd0, wb_we}, {31'd0, v.e_wb_we});
      check($sformatf("v%0d done_rdn", idx), {27'd0, rdn}, {27'd0, v.rdn_i});
      if (v.chk_data) check($sformatf("v%0d done_data", idx), wb_data, v.e_data);
      check($sformatf("v%0d done_stall", idx), {31'd0, stall}, 32'd0);
      check($sformatf("v%0d req_drop", idx), {31'd0, dmem_req}, 32'd0);
      check($sformatf("v%0d done_mis", idx), {31'd0, misalign}, 32'd0);
    end
  endtask

  initial begin
    //           rd   wr   f3      rdn   alu           sdata         rdata         N  mem  addr          be       wdata         we   wbwe data          chk  mis
    vecs[0]  = '{1'b0,1'b0,3'b000, 5'd5, 32'h0000_1234,32'h0,        32'h0,        0, 1'b0,32'h0,        4'h0,    32'h0,        1'b0,1'b1,32'h0000_1234,1'b1,1'b0};
    vecs[1]  = '{1'b0,1'b0,3'b000, 5'd0, 32'hDEAD_BEEF,32'h0,        32'h0,        0, 1'b0,32'h0,        4'h0,    32'h0,        1'b0,1'b0,32'hDEAD_BEEF,1'b1,1'b0};
    vecs[2]  = '{1'b1,1'b0,3'b000, 5'd7, 32'h0000_0103,32'h0,        32'h80FF_FF7F,2, 1'b1,32'h0000_0100,4'b1000, 32'h0,        1'b0,1'b1,32'hFFFF_FF80,1'b1,1'b0};
    vecs[3]  = '{1'b1,1'b0,3'b101, 5'd9, 32'h0000_0202,32'h0,        32'hBEEF_0000,1, 1'b1,32'h0000_0200,4'b1100, 32'h0,        1'b0,1'b1,32'h0000_BEEF,1'b1,1'b0};
    vecs[4]  = '{1'b0,1'b1,3'b001, 5'd0, 32'h0000_0302,32'hAAAA_5678,32'h0,        3, 1'b1,32'h0000_0300,4'b1100, 32'h5678_5678,1'b1,1'b0,32'h0,        1'b0,1'b0};
    vecs[5]  = '{1'b1,1'b0,3'b001, 5'd3, 32'h0000_0206,32'h0,        32'h8001_1234,1, 1'b1,32'h0000_0204,4'b1100, 32'h0,        1'b0,1'b1,32'hFFFF_8001,1'b1,1'b0};
    vecs[6]  = '{1'b1,1'b0,3'b010, 5'd31,32'h0000_040C,32'h0,        32'hCAFE_BABE,2, 1'b1,32'h0000_040C,4'b1111, 32'h0,        1'b0,1'b1,32'hCAFE_BABE,1'b1,1'b0};
    vecs[7]  = '{1'b0,1'b1,3'b000, 5'd0, 32'h0000_0501,32'h1234_56AB,32'h0,        1, 1'b1,32'h0000_0500,4'b0010, 32'hABAB_ABAB,1'b1,1'b0,32'h0,        1'b0,1'b0};
    vecs[8]  = '{1'b0,1'b1,3'b010, 5'd0, 32'h0000_0600,32'h0102_0304,32'h0,        1, 1'b1,32'h0000_0600,4'b1111, 32'h0102_0304,1'b1,1'b0,32'h0,        1'b0,1'b0};
    vecs[9]  = '{1'b1,1'b0,3'b100, 5'd0, 32'h0000_0702,32'h0,        32'h11FE_3344,1, 1'b1,32'h0000_0700,4'b0100, 32'h0,        1'b0,1'b0,32'h0000_00FE,1'b1,1'b0};
`ifdef MEM_MISALIGN_TRAP_EN
    vecs[10] = '{1'b1,1'b0,3'b010, 5'd4, 32'h0000_0401,32'h0,        32'h0,        0, 1'b0,32'h0,        4'h0,    32'h0,        1'b0,1'b0,32'h0000_0401,1'b1,1'b1};
    vecs[11] = '{1'b0,1'b1,3'b001, 5'd6, 32'h0000_0803,32'h0000_BEEF,32'h0,        0, 1'b0,32'h0,        4'h0,    32'h0,        1'b0,1'b0,32'h0000_0803,1'b1,1'b1};
`else
    vecs[10] = '{1'b1,1'b0,3'b010, 5'd4, 32'h0000_0401,32'h0,        32'h5566_7788,1, 1'b1,32'h0000_0400,4'b1111, 32'h0,        1'b0,1'b1,32'h5566_7788,1'b1,1'b0};
    vecs[11] = '{1'b0,1'b1,3'b001, 5'd6, 32'h0000_0803,32'h0000_BEEF,32'h0,        2, 1'b1,32'h0000_0800,4'b1100, 32'hBEEF_BEEF,1'b1,1'b0,32'h0,        1'b0,1'b0};
`endif

    // Reset state
    #3;
    check("rst stall", {31'd0, stall}, 32'd0);
    check("rst req", {31'd0, dmem_req}, 32'd0);
    check("rst wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst wb_data", wb_data, 32'd0);
    check("rst addr", dmem_addr, 32'd0);
    check("rst be", {28'd0, dmem_be}, 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // dmem_ready in IDLE has no effect
    dmem_ready = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    check("idle_ready stall", {31'd0, stall}, 32'd0);
    check("idle_ready req", {31'd0, dmem_req}, 32'd0);
    check("idle_ready wb_valid", {31'd0, wb_valid}, 32'd0);
    dmem_ready = 1'b0;

    // Reset while BUSY with ready held low
    valid_in = 1'b1; mem_rd = 1'b1; funct3 = 3'b010; rdn_in = 5'd12;
    alu_out = 32'h0000_0900;
    @(posedge clk); #1;
    valid_in = 1'b0; mem_rd = 1'b0;
    check("mid busy_req", {31'd0, dmem_req}, 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rstn = 1'b0;
    #1;
    check("mid rst req", {31'd0, dmem_req}, 32'd0);
    check("mid rst stall", {31'd0, stall}, 32'd0);
    check("mid rst wb_valid", {31'd0, wb_valid}, 32'd0);
    check("mid rst wb_we", {31'd0, wb_we}, 32'd0);
    check("mid rst rdn", {27'd0, rdn}, 32'd0);
    check("mid rst wb_data", wb_data, 32'd0);
    check("mid rst misalign", {31'd0, misalign}, 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    run_vec(vecs[0], 100);
    run_vec(vecs[3], 103);
    run_vec(vecs[4], 104);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the core pipeline, directly downstream of the EX/MEM register. It takes the registered ALU result, store data and destination register, performs loads and stores over a single-outstanding req/ready data-memory bus, and aligns and sign-extends load data. It also holds the MEM/WB pipeline register, and stalls upstream while a memory transaction is in flight.

## Interface
- WordSize, 32, datapath width; only 32 is supported (4 byte lanes).
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- valid_in  in  1  EX/MEM holds a live instruction
- mem_rd  in  1  instruction is a load
- mem_wr  in  1  instruction is a store; mem_rd and mem_wr are never both 1
- funct3  in  3  access size: [1:0] 00 byte, 01 half, 10 word; [2] unsigned load
- rdn_in  in  5  destination register
- alu_out  in  WordSize  effective address, or the ALU result for non-memory instructions
- mem_data  in  WordSize  store data (rs2)
- stall  out  1  upstream must hold EX/MEM contents
- dmem_req  out  1  bus request
- dmem_we  out  1  1 = write
- dmem_addr  out  WordSize  word-aligned address
- dmem_be  out  4  byte enables
- dmem_wdata  out  WordSize  lane-shifted store data
- dmem_ready  in  1  bus completes the transaction this cycle
- dmem_rdata  in  WordSize  read word, valid when dmem_ready=1
- wb_valid  out  1  MEM/WB register holds a live instruction
- wb_we  out  1  write rdn with wb_data
- rdn  out  5  destination register
- wb_data  out  WordSize  writeback value
- misalign  out  1  misaligned-access flag, registered with wb_valid

## Operation
- FSM states: IDLE and BUSY.
- IDLE behaviour:
  - valid_in=1 and neither mem_rd nor mem_wr: at the next edge the WB register loads wb_valid=1, wb_data=alu_out, rdn=rdn_in, wb_we=(rdn_in!=0). Latency is 1 cycle.
  - valid_in=1 with a load or store: capture address, size, store data and rdn. Go to BUSY. The WB register loads a bubble (wb_valid=0, wb_we=0).
  - valid_in=0: the WB register loads a bubble.
- BUSY behaviour:
  - dmem_req=1, with dmem_we/addr/be/wdata driven from the captured registers and held stable until dmem_ready=1.
  - On the edge where dmem_ready=1, return to IDLE and load the WB register.
    - Load: wb_data is the extended read value, wb_we=(rdn!=0).
    - Store: wb_valid=1, wb_we=0.
- stall = (state==BUSY), including the cycle in which dmem_ready=1. EX/MEM inputs are not sampled in BUSY.
- Address and lane rules:
  - dmem_addr = {addr[31:2], 2'b00}.
  - Byte access: be = 4'b0001 << addr[1:0]; wdata = the byte replicated into all 4 lanes.
  - Half access: be = 4'b0011 << {addr[1],1'b0}; wdata = the half replicated into both halves.
  - Word access: be = 4'b1111.
- Load extension: select the lane by the captured address bits. Zero-extend when funct3[2]=1, otherwise sign-extend from bit 7 or bit 15.
- dmem_ready is ignored in IDLE.

## Timing
- Reset values: state IDLE; stall 0, dmem_req 0, dmem_we 0, dmem_addr 0, dmem_be 0, dmem_wdata 0, wb_valid 0, wb_we 0, rdn 0, wb_data 0, misalign 0.
- Memory operation latency: 1 capture cycle plus N BUSY cycles, where N ≥ 1 is the number of cycles until dmem_ready. The minimum is 2 cycles from presentation to WB.
- dmem_req is asserted the cycle after capture and deasserts the cycle after ready. Back-to-back memory operations therefore have one IDLE cycle between requests.
- Reset mid-transaction: dmem_req drops asynchronously with rstn and the transaction is abandoned. The bus side tolerates this.

## Configuration
- MEM_MISALIGN_TRAP_EN defined:
  - Misaligned accesses are half access with addr[0]=1, or word access with addr[1:0]!=0.
  - These never enter BUSY and never request the bus.
  - At the next edge the WB register loads wb_valid=1, wb_we=0, misalign=1, wb_data=alu_out (the faulting address).
- MEM_MISALIGN_TRAP_EN undefined:
  - Offending low address bits are cleared: half uses addr[0]=0, word uses addr[1:0]=0.
  - The access proceeds normally.
  - misalign is tied to 0.

## Structure
- Package mem_pkg:
  - mem_size_e (BYTE, HALF, WORD);
  - mem_state_e (IDLE, BUSY);
  - lane/byte-enable width constant.
- Sub-module load_align: purely combinational. Inputs are rdata, addr[1:0], size and unsigned; output is the extended word. It is instantiated once.

## Test plan
- ALU pass-through: alu_out=0x1234, rdn_in=5, no mem op → next cycle wb_valid=1, wb_we=1, rdn=5, wb_data=0x1234, stall=0.
- Signed byte load: addr 0x103, funct3=000, rdata=0x80FF_FF7F, ready after 2 BUSY cycles → dmem_addr=0x100, be=4'b1000, stall high for 2 cycles, wb_data=0xFFFF_FF80.
- Unsigned half load: addr 0x202, funct3=101, rdata=0xBEEF_0000 → wb_data=0x0000_BEEF.
- Half store: addr 0x302, mem_data=0xAAAA_5678 → be=4'b1100, wdata=0x5678_5678, we=1; on completion wb_valid=1, wb_we=0.
- Misaligned word load at addr 0x401:
  - with MEM_MISALIGN_TRAP_EN: no dmem_req, misalign=1, wb_data=0x401;
  - without it: dmem_addr=0x400, be=4'b1111.
- Reset asserted while BUSY with ready held low → dmem_req, stall and all WB outputs are 0 immediately; the next op after release behaves normally.
